// File: rtl/biriscv_fencei_ctrl.sv
// FENCE.I sequencer: stalls fetch, drains the LSU, writes back the D-cache,
// invalidates the I-cache, then issues one redirect to the post-fence PC.
module biriscv_fencei_ctrl #(
  parameter int SUPPORT_DCACHE_FLUSH = 1,
  parameter int MIN_DRAIN_CYCLES     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fence_req_i,
  input  logic [31:0] fence_pc_i,
  input  logic [1:0]  fence_priv_i,
  input  logic        abort_i,
  input  logic        lsu_idle_i,
  input  logic        dcache_flush_accept_i,
  input  logic        dcache_flush_done_i,
  input  logic        icache_inv_accept_i,
  input  logic        icache_inv_done_i,
  output logic        busy_o,
  output logic        fetch_stall_o,
  output logic        dcache_flush_o,
  output logic        icache_invalidate_o,
  output logic        branch_request_o,
  output logic [31:0] branch_pc_o,
  output logic [1:0]  branch_priv_o,
  output logic [15:0] fence_count_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_DFLUSH,
    ST_DWAIT,
    ST_IINV,
    ST_IWAIT,
    ST_REDIRECT
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(MIN_DRAIN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [1:0]  priv_q;
  logic        abort_q;
  logic [3:0]  drain_cnt_q;
  logic [15:0] fence_count_q, fence_count_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (fence_req_i) state_d = ST_DRAIN;
      ST_DRAIN:    if (drain_cnt_q == 4'd0 && lsu_idle_i)
                     state_d = (SUPPORT_DCACHE_FLUSH != 0) ? ST_DFLUSH : ST_IINV;
      ST_DFLUSH:   if (dcache_flush_accept_i) state_d = ST_DWAIT;
      // Done is only looked at here, so a done raised alongside its accept is ignored.
      ST_DWAIT:    if (dcache_flush_done_i) state_d = ST_IINV;
      ST_IINV:     if (icache_inv_accept_i) state_d = ST_IWAIT;
      ST_IWAIT:    if (icache_inv_done_i) state_d = ST_REDIRECT;
      ST_REDIRECT: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fence_count_d = fence_count_q;
    if (state_q == ST_REDIRECT && fence_count_q != 16'hFFFF)
      fence_count_d = fence_count_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      pc_q          <= 32'd0;
      priv_q        <= 2'b11;
      abort_q       <= 1'b0;
      drain_cnt_q   <= 4'd0;
      fence_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      fence_count_q <= fence_count_d;
      if (state_q == ST_IDLE) begin
        if (fence_req_i) begin
          pc_q        <= fence_pc_i;
          priv_q      <= fence_priv_i;
          abort_q     <= 1'b0;
          drain_cnt_q <= DRAIN_LOAD;
        end
      end else if (abort_i) begin
        // Cache maintenance still completes; only the final redirect is suppressed.
        abort_q <= 1'b1;
      end
      if (state_q == ST_DRAIN && drain_cnt_q != 4'd0)
        drain_cnt_q <= drain_cnt_q - 4'd1;
    end
  end

  assign busy_o              = (state_q != ST_IDLE);
  assign fetch_stall_o       = busy_o;
  assign dcache_flush_o      = (state_q == ST_DFLUSH);
  assign icache_invalidate_o = (state_q == ST_IINV);
  assign branch_request_o    = (state_q == ST_REDIRECT) && !abort_q;
  assign branch_pc_o         = pc_q;
  assign branch_priv_o       = priv_q;
  assign fence_count_o       = fence_count_q;

endmodule
